// File: rtl/health_scan_scheduler.sv
// health_scan_scheduler: round-robin sensor scan, per-channel debounce, latched alarm reporting.
// Define HEALTH_SCAN_ROUND_STAMP_EN to add the alarm_round stamp output.
module health_scan_scheduler #(
    parameter int DEBOUNCE = 3,
    parameter int PERIOD = 100,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        clr_alarm,
    output logic        sns_req,
    output logic [2:0]  sns_sel,
    input  logic        sns_ack,
    input  logic [4:0]  abn_flags,
    output logic        alarm_valid,
    input  logic        alarm_ready,
    output logic [2:0]  alarm_chan,
    output logic [4:0]  alarm_mask,
`ifdef HEALTH_SCAN_ROUND_STAMP_EN
    output logic [15:0] alarm_round,
`endif
    output logic        timeout_err
);
    typedef enum logic [2:0] {IDLE, REQ, EVAL, REPORT, WAIT} state_t;
    localparam int TW = $clog2(TIMEOUT);
    localparam int PW = $clog2(PERIOD + 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);
    state_t state, stateNext;
    logic [2:0] ch;
    logic [TW-1:0] tmoCnt;
    logic [PW-1:0] perCnt;
    logic [3:0] debCnt [5];
    logic [3:0] evalCnt;
    logic sample, tmoHit, perHit, confirm, advance;
    assign tmoHit = tmoCnt == TW'(TIMEOUT - 1);
    assign perHit = perCnt == PW'(PERIOD - 1);
    assign evalCnt = sample ? (debCnt[ch] == DEB ? DEB : debCnt[ch] + 4'd1) : 4'd0;
    assign confirm = state == EVAL && evalCnt == DEB && !alarm_mask[ch];
    assign sns_req = state == REQ;
    assign sns_sel = sns_req ? ch : 3'd0;
    assign alarm_valid = state == REPORT;
    assign alarm_chan = alarm_valid ? ch : 3'd0;
    // Advancing to the next channel is a transition action, not a state of its own.
    always_comb begin
        stateNext = state;
        advance = 1'b0;
        case (state)
            IDLE: stateNext = scan_en ? REQ : IDLE;
            REQ: begin
                stateNext = sns_ack ? EVAL : REQ;
                advance = !sns_ack && tmoHit;
            end
            EVAL: begin
                stateNext = confirm ? REPORT : EVAL;
                advance = !confirm;
            end
            REPORT: advance = alarm_ready;
            WAIT: stateNext = !scan_en ? IDLE : perHit ? REQ : WAIT;
            default: stateNext = IDLE;
        endcase
        if (advance) stateNext = ch != 3'd4 ? REQ : scan_en ? WAIT : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch <= '0;
            tmoCnt <= '0;
            perCnt <= '0;
            sample <= 1'b0;
            alarm_mask <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < 5; i++) debCnt[i] <= '0;
        end else begin
            state <= stateNext;
            tmoCnt <= state == REQ && !tmoHit ? tmoCnt + 1'b1 : '0;
            perCnt <= state == WAIT ? perCnt + 1'b1 : '0;
            if (sns_req && sns_ack) sample <= abn_flags[ch];
            if (advance) ch <= ch == 3'd4 ? 3'd0 : ch + 3'd1;
            if (clr_alarm) begin
                alarm_mask <= '0;
                timeout_err <= 1'b0;
                for (int i = 0; i < 5; i++) debCnt[i] <= '0;
            end
            // Updates from the current cycle override a coincident clear.
            if (state == EVAL) debCnt[ch] <= evalCnt;
            if (confirm) alarm_mask[ch] <= 1'b1;
            if (state == REQ && advance) timeout_err <= 1'b1;
        end
    end
`ifdef HEALTH_SCAN_ROUND_STAMP_EN
    logic [15:0] roundCnt;
    always_ff @(posedge clk) begin
        if (rst || clr_alarm) roundCnt <= '0;
        else if (advance && ch == 3'd4) roundCnt <= roundCnt + 16'd1;
        if (rst) alarm_round <= '0;
        else if (confirm) alarm_round <= roundCnt;
    end
`endif
endmodule

// File: tb/tb_health_scan_scheduler.sv
// tb_health_scan_scheduler: table-driven round scenarios plus randomized rounds against a debounce model.
module tb_health_scan_scheduler;
    localparam int DEB = 3, PER = 100, TMO = 16;
    logic clk = 1'b0;
    logic rst, scan_en, clr_alarm, sns_ack, alarm_ready;
    logic [4:0] abn_flags;
    logic sns_req, alarm_valid, timeout_err;
    logic [2:0] sns_sel, alarm_chan;
    logic [4:0] alarm_mask;
`ifdef HEALTH_SCAN_ROUND_STAMP_EN
    logic [15:0] alarm_round;
`endif
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    health_scan_scheduler #(.DEBOUNCE(DEB), .PERIOD(PER), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .clr_alarm(clr_alarm),
        .sns_req(sns_req), .sns_sel(sns_sel), .sns_ack(sns_ack), .abn_flags(abn_flags),
        .alarm_valid(alarm_valid), .alarm_ready(alarm_ready), .alarm_chan(alarm_chan),
        .alarm_mask(alarm_mask),
`ifdef HEALTH_SCAN_ROUND_STAMP_EN
        .alarm_round(alarm_round),
`endif
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [4:0] flags;
        logic [4:0] noAck;
        int ackDly;
        int rdyDly;
        logic [4:0] expRep;
        logic [4:0] expMask;
        logic expTmo;
        logic clrAfter;
    } row_t;
    row_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Services one request: ackDly<0 means never acknowledge.
    task automatic serve(input int expSel, input int expGap, input int ackDly,
                         input logic flag, input int rdyDly, input logic expRep);
        int n, bad;
        n = 0;
        while (!sns_req && n < 400) begin
            step();
            n++;
        end
        if (!sns_req) begin
            chk("req_wait", 0, 1);
            return;
        end
        if (expGap >= 0) chk("round_gap", n, expGap);
        chk("sns_sel", sns_sel, expSel);
        abn_flags = 5'($urandom);
        abn_flags[expSel] = flag;
        if (ackDly < 0) begin
            n = 0;
            while (sns_req && sns_sel == 3'(expSel) && n < 100) begin
                abn_flags = 5'($urandom);
                step();
                n++;
            end
            chk("tmo_len", n, TMO);
            chk("tmo_err", timeout_err, 1);
            chk("tmo_next_req", sns_req, expSel < 4 ? 1 : 0);
            if (expSel < 4) chk("tmo_next_sel", sns_sel, expSel + 1);
            return;
        end
        bad = 0;
        repeat (ackDly) begin
            step();
            if (!sns_req || sns_sel != 3'(expSel)) bad++;
        end
        chk("req_hold", bad, 0);
        sns_ack = 1'b1;
        step();
        sns_ack = 1'b0;
        abn_flags = 5'($urandom);
        chk("eval_quiet", {sns_req, alarm_valid}, 0);
        step();
        chk("alarm_valid", alarm_valid, expRep);
        if (alarm_valid) begin
            chk("alarm_chan", alarm_chan, expSel);
            bad = 0;
            repeat (rdyDly) begin
                step();
                if (!alarm_valid || alarm_chan != 3'(expSel) || sns_req) bad++;
            end
            chk("report_hold", bad, 0);
            alarm_ready = 1'b1;
            step();
            alarm_ready = 1'b0;
            chk("report_done", alarm_valid, 0);
        end
        if (expSel < 4) begin
            chk("next_req", sns_req, 1);
            chk("next_sel", sns_sel, expSel + 1);
        end else chk("round_end", sns_req, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gap, ackD, n;
        int cnt [5];
        logic [4:0] mMask;
        logic mTmo, f, rep;
        rst = 1'b1; scan_en = 1'b0; clr_alarm = 1'b0; sns_ack = 1'b0;
        alarm_ready = 1'b0; abn_flags = '0;
        tbl[0] = '{5'b10001, 5'b00000, 1, 0,  5'b00000, 5'b00000, 1'b0, 1'b0};
        tbl[1] = '{5'b10001, 5'b00000, 0, 0,  5'b00000, 5'b00000, 1'b0, 1'b0};
        tbl[2] = '{5'b00001, 5'b00000, 1, 20, 5'b00001, 5'b00001, 1'b0, 1'b0};
        tbl[3] = '{5'b10001, 5'b00000, 2, 0,  5'b00000, 5'b00001, 1'b0, 1'b0};
        tbl[4] = '{5'b10001, 5'b00100, 1, 0,  5'b00000, 5'b00001, 1'b1, 1'b0};
        tbl[5] = '{5'b10001, 5'b00000, 0, 2,  5'b10000, 5'b10001, 1'b1, 1'b1};
        tbl[6] = '{5'b00001, 5'b00000, 1, 0,  5'b00000, 5'b00000, 1'b0, 1'b0};
        tbl[7] = '{5'b00001, 5'b00000, 3, 0,  5'b00000, 5'b00000, 1'b0, 1'b0};
        tbl[8] = '{5'b00001, 5'b00000, 1, 1,  5'b00001, 5'b00001, 1'b0, 1'b0};
        repeat (2) step();
        rst = 1'b0;
        chk("reset_outs", {sns_req, sns_sel, alarm_valid, alarm_chan, alarm_mask, timeout_err}, 0);
        scan_en = 1'b1;
        gap = 1;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 5; c++)
                serve(c, c == 0 ? gap : -1, tbl[r].noAck[c] ? -1 : tbl[r].ackDly,
                      tbl[r].flags[c], tbl[r].rdyDly, tbl[r].expRep[c]);
            gap = PER;
            chk("tbl_mask", alarm_mask, tbl[r].expMask);
            chk("tbl_tmo", timeout_err, tbl[r].expTmo);
            if (tbl[r].clrAfter) begin
                clr_alarm = 1'b1;
                step();
                clr_alarm = 1'b0;
                chk("clr_mask", alarm_mask, 0);
                chk("clr_tmo", timeout_err, 0);
                gap = PER - 1;
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        gap = 1;
        mMask = '0;
        mTmo = 1'b0;
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 5; c++) begin
                ackD = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
                f = $urandom_range(0, 3) != 0;
                rep = 1'b0;
                if (ackD < 0) mTmo = 1'b1;
                else begin
                    cnt[c] = f ? (cnt[c] < DEB ? cnt[c] + 1 : DEB) : 0;
                    rep = cnt[c] == DEB && !mMask[c];
                    if (rep) mMask[c] = 1'b1;
                end
                if (r == 5 && c == 2) scan_en = 1'b0;
                serve(c, c == 0 ? gap : -1, ackD, f, int'($urandom_range(0, 3)), rep);
            end
            gap = PER;
            chk("rnd_mask", alarm_mask, mMask);
            chk("rnd_tmo", timeout_err, mTmo);
            if (r < 5 && $urandom_range(0, 2) == 0) begin
                clr_alarm = 1'b1;
                step();
                clr_alarm = 1'b0;
                mMask = '0;
                mTmo = 1'b0;
                for (int i = 0; i < 5; i++) cnt[i] = 0;
                chk("rnd_clr_mask", alarm_mask, 0);
                gap = PER - 1;
            end
        end
        n = 0;
        repeat (150) begin
            step();
            if (sns_req) n++;
        end
        chk("idle_after_stop", n, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        scan_en = 1'b1;
        abn_flags = 5'b11111;
        n = 0;
        while (!alarm_valid && n < 1000) begin
            sns_ack = sns_req;
            step();
            n++;
        end
        sns_ack = 1'b0;
        chk("pre_rst_alarm", alarm_valid, 1);
        chk("pre_rst_chan", alarm_chan, 0);
        scan_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_in_report", {sns_req, sns_sel, alarm_valid, alarm_chan, alarm_mask, timeout_err}, 0);
        step();
        chk("post_rst_quiet", {sns_req, alarm_valid, alarm_mask}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
